// File: rtl/reg_file_8x8_pkg.sv
// Shared CPU definitions: register file geometry and architectural register indices,
// common to the register file, ALU and control unit.
package reg_file_8x8_pkg;

  localparam int unsigned CPU_WIDTH  = 8;
  localparam int unsigned CPU_DEPTH  = 8;
  localparam int unsigned CPU_AW     = 3;
  localparam int unsigned CPU_BYPASS = 1;

  typedef logic [CPU_AW-1:0] reg_idx_t;

  localparam reg_idx_t R0 = 3'd0;
  localparam reg_idx_t R1 = 3'd1;
  localparam reg_idx_t R2 = 3'd2;
  localparam reg_idx_t R3 = 3'd3;
  localparam reg_idx_t R4 = 3'd4;
  localparam reg_idx_t R5 = 3'd5;
  localparam reg_idx_t R6 = 3'd6;
  localparam reg_idx_t R7 = 3'd7;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending (busy) bits for multi-cycle ops and the operand STALL flag.
// A mark issued in the same cycle as a write-back to that register wins.
module reg_scoreboard
  import reg_file_8x8_pkg::*;
#(
  parameter  int unsigned DEPTH = CPU_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          fwd_en,
  input  logic [AW-1:0] rd1_addr,
  input  logic [AW-1:0] rd2_addr,
  output logic          stall
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             hit1;
  logic             hit2;

  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  // A forwarded write-back resolves the pending operand in the same cycle.
  always_comb begin
    hit1  = fwd_en && (clr_addr == rd1_addr);
    hit2  = fwd_en && (clr_addr == rd2_addr);
    stall = 1'b0;
    if (reset_n) begin
      stall = (busy[rd1_addr] && !hit1) || (busy[rd2_addr] && !hit2);
    end
  end

endmodule

// File: rtl/reg_file_8x8.sv
// Two-read, one-write register file with optional write-to-read forwarding
// and a busy scoreboard that stalls issue on pending operands.
module reg_file_8x8
  import reg_file_8x8_pkg::*;
#(
  parameter  int unsigned WIDTH  = CPU_WIDTH,
  parameter  int unsigned DEPTH  = CPU_DEPTH,
  parameter  int unsigned BYPASS = CPU_BYPASS,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    INADDRESS,
  input  logic             WRITE,
  input  logic [AW-1:0]    OUT1ADDRESS,
  input  logic [AW-1:0]    OUT2ADDRESS,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  input  logic             BUSY_SET,
  input  logic [AW-1:0]    BUSY_ADDR,
  output logic             STALL
);

  localparam bit BYP = (BYPASS != 0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_fire;
  logic             fwd_en;

  assign wr_fire = WRITE && RESET_N;
  assign fwd_en  = BYP && wr_fire;

  always_ff @(posedge CLK) begin
    if (!RESET_N)   regs <= '{default: '0};
    else if (WRITE) regs[INADDRESS] <= IN;
  end

  // Outputs are forced to zero while reset is held, so a pending write cannot leak out.
  always_comb begin
    OUT1 = '0;
    OUT2 = '0;
    if (RESET_N) begin
      OUT1 = (fwd_en && (INADDRESS == OUT1ADDRESS)) ? IN : regs[OUT1ADDRESS];
      OUT2 = (fwd_en && (INADDRESS == OUT2ADDRESS)) ? IN : regs[OUT2ADDRESS];
    end
  end

  reg_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk      (CLK),
    .reset_n  (RESET_N),
    .set_en   (BUSY_SET),
    .set_addr (BUSY_ADDR),
    .clr_en   (WRITE),
    .clr_addr (INADDRESS),
    .fwd_en   (fwd_en),
    .rd1_addr (OUT1ADDRESS),
    .rd2_addr (OUT2ADDRESS),
    .stall    (STALL)
  );

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed bench for reg_file_8x8; a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_reg_file_8x8;
  import reg_file_8x8_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, wr, bset;
  logic [7:0] in_d;
  logic [2:0] in_a, a1, a2, baddr;
  logic [7:0] o1, o2, o1n, o2n;
  logic       st, stn;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  reg_file_8x8 #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) dut_b1 (
    .CLK(clk), .RESET_N(rst_n), .IN(in_d), .INADDRESS(in_a), .WRITE(wr),
    .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(o1), .OUT2(o2),
    .BUSY_SET(bset), .BUSY_ADDR(baddr), .STALL(st)
  );

  reg_file_8x8 #(.WIDTH(8), .DEPTH(8), .BYPASS(0)) dut_b0 (
    .CLK(clk), .RESET_N(rst_n), .IN(in_d), .INADDRESS(in_a), .WRITE(wr),
    .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(o1n), .OUT2(o2n),
    .BUSY_SET(bset), .BUSY_ADDR(baddr), .STALL(stn)
  );

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    in_a = a; in_d = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr = 1'b1; in_d = 8'hFF; in_a = R0;
    bset = 1'b1; baddr = R0; a1 = R0; a2 = R0;
    @(posedge clk); #1;
    tests++; if (o1 !== 8'h00) begin fails++; $display("FAIL rst_hold_out1: got %h exp %h", o1, 8'h00); end
    tests++; if (st !== 1'b0) begin fails++; $display("FAIL rst_hold_stall: got %b exp %b", st, 1'b0); end
    @(negedge clk);
    rst_n = 1'b1; wr = 1'b0; bset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = 3'(i); a2 = 3'(7 - i);
      #2;
      tests++; if (o1 !== 8'h00 || o2 !== 8'h00) begin fails++; $display("FAIL rst_regs_%0d: got %h/%h exp 00/00", i, o1, o2); end
      tests++; if (st !== 1'b0 || stn !== 1'b0) begin fails++; $display("FAIL rst_stall_%0d: got %b/%b exp 0/0", i, st, stn); end
    end
  endtask

  task automatic test_write_read;
    wr_reg(R3, 8'h12);
    wr_reg(R5, 8'h34);
    a1 = R3; a2 = R5; #2;
    tests++; if (o1 !== 8'h12) begin fails++; $display("FAIL wr_r3: got %h exp %h", o1, 8'h12); end
    tests++; if (o2 !== 8'h34) begin fails++; $display("FAIL wr_r5: got %h exp %h", o2, 8'h34); end
    tests++; if (o1n !== 8'h12 || o2n !== 8'h34) begin fails++; $display("FAIL wr_nobyp: got %h/%h exp 12/34", o1n, o2n); end
    a1 = R5; a2 = R5; #2;
    tests++; if (o1 !== 8'h34 || o2 !== 8'h34) begin fails++; $display("FAIL same_sel: got %h/%h exp 34/34", o1, o2); end
    a1 = R7; a2 = R4; #2;
    tests++; if (o1 !== 8'h00 || o2 !== 8'h00) begin fails++; $display("FAIL untouched: got %h/%h exp 00/00", o1, o2); end
  endtask

  task automatic test_bypass;
    wr_reg(R2, 8'h01);
    wr = 1'b1; in_a = R2; in_d = 8'h7A; a1 = R2; a2 = R3;
    #2;
    tests++; if (o1 !== 8'h7A) begin fails++; $display("FAIL byp_fwd: got %h exp %h", o1, 8'h7A); end
    tests++; if (o1n !== 8'h01) begin fails++; $display("FAIL byp_off_old: got %h exp %h", o1n, 8'h01); end
    tests++; if (o2 !== 8'h12) begin fails++; $display("FAIL byp_other_port: got %h exp %h", o2, 8'h12); end
    @(negedge clk);
    wr = 1'b0; #2;
    tests++; if (o1 !== 8'h7A || o1n !== 8'h7A) begin fails++; $display("FAIL byp_after_edge: got %h/%h exp 7a/7a", o1, o1n); end
  endtask

  task automatic test_scoreboard;
    @(negedge clk);
    bset = 1'b1; baddr = R4; a1 = R0; a2 = R4; #2;
    tests++; if (st !== 1'b0) begin fails++; $display("FAIL sb_pre_mark: got %b exp %b", st, 1'b0); end
    @(negedge clk);
    bset = 1'b0; #2;
    tests++; if (st !== 1'b1 || stn !== 1'b1) begin fails++; $display("FAIL sb_marked: got %b/%b exp 1/1", st, stn); end
    @(negedge clk);
    wr = 1'b1; in_a = R4; in_d = 8'h09; #2;
    tests++; if (st !== 1'b0) begin fails++; $display("FAIL sb_fwd_mask: got %b exp %b", st, 1'b0); end
    tests++; if (stn !== 1'b1) begin fails++; $display("FAIL sb_nofwd_stall: got %b exp %b", stn, 1'b1); end
    @(negedge clk);
    wr = 1'b0; #2;
    tests++; if (st !== 1'b0 || stn !== 1'b0) begin fails++; $display("FAIL sb_cleared: got %b/%b exp 0/0", st, stn); end
    tests++; if (o2 !== 8'h09 || o2n !== 8'h09) begin fails++; $display("FAIL sb_data: got %h/%h exp 09/09", o2, o2n); end
  endtask

  task automatic test_collision;
    @(negedge clk);
    bset = 1'b1; baddr = R6; wr = 1'b1; in_a = R6; in_d = 8'hC3; a1 = R6; a2 = R0; #2;
    tests++; if (o1 !== 8'hC3 || o1n !== 8'h00) begin fails++; $display("FAIL col_pre: got %h/%h exp c3/00", o1, o1n); end
    tests++; if (st !== 1'b0 || stn !== 1'b0) begin fails++; $display("FAIL col_pre_stall: got %b/%b exp 0/0", st, stn); end
    @(negedge clk);
    bset = 1'b0; wr = 1'b0; #2;
    tests++; if (o1 !== 8'hC3 || o1n !== 8'hC3) begin fails++; $display("FAIL col_data: got %h/%h exp c3/c3", o1, o1n); end
    tests++; if (st !== 1'b1 || stn !== 1'b1) begin fails++; $display("FAIL col_set_wins: got %b/%b exp 1/1", st, stn); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    wr = 1'b1; in_a = R0; in_d = 8'hA0;
    @(negedge clk);
    in_a = R1; in_d = 8'hB1;
    @(negedge clk);
    in_a = R2; in_d = 8'hC2;
    @(negedge clk);
    wr = 1'b0; a1 = R0; a2 = R1; #2;
    tests++; if (o1 !== 8'hA0 || o2 !== 8'hB1) begin fails++; $display("FAIL b2b_r0r1: got %h/%h exp a0/b1", o1, o2); end
    a1 = R2; a2 = R6; #2;
    tests++; if (o1 !== 8'hC2 || o2 !== 8'hC3) begin fails++; $display("FAIL b2b_r2r6: got %h/%h exp c2/c3", o1, o2); end
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL b2b_r6_busy: got %b exp %b", st, 1'b1); end
  endtask

  task automatic test_mid_reset;
    wr_reg(R1, 8'h55);
    bset = 1'b1; baddr = R1;
    @(negedge clk);
    bset = 1'b0; a1 = R1; a2 = R0; #2;
    tests++; if (st !== 1'b1 || o1 !== 8'h55) begin fails++; $display("FAIL mid_pre: got %b/%h exp 1/55", st, o1); end
    @(negedge clk);
    rst_n = 1'b0; wr = 1'b1; in_a = R1; in_d = 8'hAA; bset = 1'b1; baddr = R2; a2 = R2; #2;
    tests++; if (o1 !== 8'h00 || st !== 1'b0) begin fails++; $display("FAIL mid_during: got %h/%b exp 00/0", o1, st); end
    @(negedge clk);
    rst_n = 1'b1; wr = 1'b0; bset = 1'b0; #2;
    tests++; if (o1 !== 8'h00 || o1n !== 8'h00) begin fails++; $display("FAIL mid_r1: got %h/%h exp 00/00", o1, o1n); end
    tests++; if (st !== 1'b0 || stn !== 1'b0) begin fails++; $display("FAIL mid_stall: got %b/%b exp 0/0", st, stn); end
    a1 = R6; #2;
    tests++; if (o1 !== 8'h00 || st !== 1'b0) begin fails++; $display("FAIL mid_r6: got %h/%b exp 00/0", o1, st); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_8x8.md
REG_FILE_8X8 -- requirements
Module: reg_file_8x8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register data width.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (address width 3).
REQ-003 SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding.
REQ-004 SHALL have port CLK  input  1  single clock, rising-edge active.
REQ-005 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port IN  input  8  write-back data, from ALU result.
REQ-007 SHALL have port INADDRESS  input  3  write destination register.
REQ-008 SHALL have port WRITE  input  1  write enable.
REQ-009 SHALL have port OUT1ADDRESS  input  3  read port 1 select.
REQ-010 SHALL have port OUT2ADDRESS  input  3  read port 2 select.
REQ-011 SHALL have port OUT1  output  8  operand 1 to ALU IN1/forward unit.
REQ-012 SHALL have port OUT2  output  8  operand 2 to ALU IN2.
REQ-013 SHALL have port BUSY_SET  input  1  mark destination pending (multi-cycle op issued).
REQ-014 SHALL have port BUSY_ADDR  input  3  register to mark pending.
REQ-015 SHALL have port STALL  output  1  high while either selected operand is pending.

Function
REQ-016 SHALL write IN to register INADDRESS on rising CLK when WRITE=1 and RESET_N=1, with #1 delay.
REQ-017 SHALL drive OUT1/OUT2 combinationally from the addressed registers, with #2 delay after address or data change.
REQ-018 With BYPASS=1, SHALL return IN on a read port whose address equals INADDRESS while WRITE=1 (same-cycle forwarding); with BYPASS=0, old value until the edge.
REQ-019 SHALL allow both read ports to select the same register; both return identical data.
REQ-020 SHALL keep a per-register busy bit: set on rising CLK when BUSY_SET=1 for BUSY_ADDR; cleared on rising CLK by WRITE=1 to that register.
REQ-021 SHALL give set priority when BUSY_SET and WRITE target the same register in one cycle (bit ends set).
REQ-022 SHALL drive STALL = busy[OUT1ADDRESS] OR busy[OUT2ADDRESS], combinationally; with BYPASS=1 a same-cycle WRITE to that busy address masks its contribution.
REQ-023 SHALL ignore WRITE and BUSY_SET in any cycle with RESET_N=0.
REQ-024 SHALL leave unaddressed registers and busy bits unchanged on every edge.

Reset
REQ-025 SHALL clear all registers to 8'h00 and all busy bits to 0 on the first rising CLK with RESET_N=0.
REQ-026 SHALL hold outputs at OUT1=OUT2=8'h00, STALL=0 from that edge while RESET_N stays low, regardless of WRITE.
REQ-027 SHALL discard an in-flight write or busy mark coinciding with reset (reset wins).
REQ-028 SHALL leave state undefined (X) before the first reset edge; bench must reset before checking.

Structure
REQ-029 SHALL take WIDTH, DEPTH, address width and register-index macros from the shared CPU definitions header, also used by the ALU and control unit.
REQ-030 SHALL implement the busy bits and STALL logic in one sub-module, reg_scoreboard; storage and read muxes stay in reg_file_8x8.
REQ-031 SHALL contain no latches; storage is a reg array updated only in the CLK always-block.

Verification
REQ-032 Reset: WRITE=1, IN=8'hFF, RESET_N=0 one edge -> all 8 registers read 8'h00, STALL=0.
REQ-033 Write/read: write 8'h12 to R3, 8'h34 to R5; OUT1ADDRESS=3, OUT2ADDRESS=5 -> OUT1=8'h12, OUT2=8'h34 after #2.
REQ-034 Bypass: R2=8'h01, same cycle WRITE IN=8'h7A INADDRESS=2, OUT1ADDRESS=2 -> OUT1=8'h7A before the edge (BYPASS=1), 8'h01 (BYPASS=0).
REQ-035 Scoreboard: BUSY_SET R4, then OUT2ADDRESS=4 -> STALL=1; WRITE R4=8'h09 -> STALL=0 after edge, OUT2=8'h09.
REQ-036 Collision: BUSY_SET and WRITE both to R6 same edge -> R6 holds written data, STALL=1 when R6 selected.
REQ-037 Mid-op reset: R1 busy with value 8'h55, RESET_N=0 one edge -> R1=8'h00, busy cleared, STALL=0.
